gcd_req_arbiter: RTL and testbench
==================================

GCD_REQ_ARBITER -- requirements
Module: gcd_req_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters.
REQ-002 Parameter WIDTH, default 16: operand and result width.
REQ-003 Parameter TIMEOUT_CYC, default 1024: engine watchdog limit in cycles, used only with the timeout option.
REQ-004 clk  input  1  single clock; all logic SHALL be on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  NREQ  per-requester operation request; held until accepted.
REQ-007 req_a, req_b  input  NREQ*WIDTH  packed operand pairs; slice i belongs to requester i.
REQ-008 req_ready  output  NREQ  one-hot acceptance strobe.
REQ-009 rsp_valid  output  NREQ  one-hot, one-cycle result strobe.
REQ-010 rsp_data  output  WIDTH  shared result bus; valid only while any rsp_valid bit is high.
REQ-011 rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-012 eng_start  output  1  one-cycle start pulse to the shared GCD engine.
REQ-013 eng_data  output  WIDTH  serial operand bus: A in the eng_start cycle, B in the following cycle.
REQ-014 eng_done  input  1  engine completion; sampled only in the WAIT state.
REQ-015 eng_result  input  WIDTH  engine result; valid while eng_done is high.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, WAIT and RESP.
REQ-017 IDLE: round-robin select over req_valid, searching from (last_grant+1) mod NREQ; req_ready[sel] high combinationally in the same cycle.
REQ-018 Acceptance happens on the edge where req_valid[i]&req_ready[i]: operands and the requester id are captured and last_grant is set to i.
REQ-019 Only one req_ready bit SHALL be high in any cycle, and only in IDLE.
REQ-020 Captured A=0 or B=0 SHALL bypass the engine: IDLE->RESP with result A|B (0,0 gives 0); the engine is not started.
REQ-021 Otherwise IDLE->LOAD_A; LOAD_A drives eng_start=1 and eng_data=A; LOAD_B drives eng_start=0 and eng_data=B; LOAD_A->LOAD_B->WAIT unconditionally.
REQ-022 WAIT->RESP on the first cycle with eng_done=1; eng_result is registered on that edge.
REQ-023 RESP: rsp_valid[id]=1 for exactly one cycle with the registered result on rsp_data, then ->IDLE.
REQ-024 The next acceptance SHALL occur no earlier than the cycle after RESP; requests arriving mid-operation wait.
REQ-025 Latency from acceptance edge to rsp_valid: 1 cycle for bypass; otherwise 3 + engine cycles.
REQ-026 A requester dropping req_valid before acceptance is legal and is simply not granted.
REQ-027 eng_done outside WAIT SHALL be ignored.
REQ-028 eng_data SHALL be 0 outside LOAD_A and LOAD_B.

Reset
REQ-029 When rst is high at an edge, the block SHALL go to IDLE with last_grant=NREQ-1, so that requester 0 has priority.
REQ-030 The same reset SHALL clear all of the following: req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_data and the watchdog.
REQ-031 Reset mid-operation SHALL abandon the operation with no response.
REQ-032 rst asserted in the same cycle as eng_done SHALL take priority over the response.

Configuration
REQ-033 With macro GCD_ARB_TIMEOUT_EN defined, a watchdog counts WAIT cycles.
REQ-034 When the watchdog reaches TIMEOUT_CYC without eng_done, the block SHALL go ->RESP with rsp_data=0 and rsp_err=1.
REQ-035 The watchdog SHALL clear on every entry to WAIT.
REQ-036 eng_done and the timeout in the same cycle: eng_done wins and rsp_err=0.
REQ-037 Without the macro, there SHALL be no counter logic, rsp_err is tied 0, and WAIT is unbounded.

Structure
REQ-038 The shared package gcd_pkg SHALL hold the FSM state encoding, the default WIDTH/NREQ/TIMEOUT_CYC constants and the round-robin helper.
REQ-039 Sub-module rr_arbiter (NREQ-wide request vector plus last_grant in, one-hot grant out, purely combinational) SHALL be instantiated once; everything else is in gcd_req_arbiter.

Verification
REQ-040 Req0: A=143, B=78; engine model returns 13 -> eng_data sequence 143 then 78, rsp_valid[0] with rsp_data=13, rsp_err=0.
REQ-041 All four requesters held valid for 3 rounds -> grant order 0,1,2,3,0,1,2,3,...; no requester granted twice before the others.
REQ-042 Req2: A=0, B=45 -> rsp_data=45 one cycle after acceptance, eng_start never asserted; A=0, B=0 -> rsp_data=0.
REQ-043 rst pulsed during WAIT for req1, then eng_done -> no rsp_valid; the next grant goes to requester 0.
REQ-044 With GCD_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, engine never done -> rsp_valid after 8 WAIT cycles with rsp_data=0 and rsp_err=1; eng_done on cycle 8 -> rsp_err=0.
REQ-045 Spurious eng_done pulse while in IDLE -> no response, FSM stays in IDLE.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD request arbiter: default sizes, FSM encoding, round-robin helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package gcd_pkg;

    localparam int GCD_NREQ_DEF    = 4;
    localparam int GCD_WIDTH_DEF   = 16;
    localparam int GCD_TIMEOUT_DEF = 1024;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    // Requester index visited at search step k (1..n) after last, wrapping modulo n.
    function automatic int rr_idx(input int last, input int k, input int n);
        int idx;
        idx = last + k;
        if (idx >= n) begin
            idx = idx - n;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant of the first active request after last_grant.
// Latency: purely combinational.
// Backpressure: none; grant simply follows the request vector.
import gcd_pkg::*;

module rr_arbiter #(
    parameter int NREQ = GCD_NREQ_DEF,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'(rr_idx(int'(last_grant), k, NREQ));
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_req_arbiter.sv
// Shares one serial GCD engine among NREQ requesters; GCD_ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: 1 cycle accept->response on zero operand, else 3 + engine cycles.
// Backpressure: one operation in flight; other requesters hold req_valid until granted in IDLE.
import gcd_pkg::*;

module gcd_req_arbiter #(
    parameter int NREQ        = GCD_NREQ_DEF,
    parameter int WIDTH       = GCD_WIDTH_DEF,
    parameter int TIMEOUT_CYC = GCD_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  eng_start,
    output logic [WIDTH-1:0]      eng_data,
    input  logic                  eng_done,
    input  logic [WIDTH-1:0]      eng_result
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [2:0]       state;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;

    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    sel_idx;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             accept;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        sel_idx = '0;
        a_sel   = '0;
        b_sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_idx = IW'(i);
                a_sel   = req_a[i*WIDTH +: WIDTH];
                b_sel   = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grant only follows active requests, so any grant bit in IDLE is an acceptance.
    assign accept    = (state == ST_IDLE) && (|grant) && !rst;
    assign req_ready = accept ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= IW'(NREQ - 1);
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
            wd_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_q        <= a_sel;
                        b_q        <= b_sel;
                        id_q       <= sel_idx;
                        last_grant <= sel_idx;
                        // gcd(x,0) = x, so a zero operand never needs the engine.
                        if ((a_sel == '0) || (b_sel == '0)) begin
                            result_q <= a_sel | b_sel;
`ifdef GCD_ARB_TIMEOUT_EN
                            err_q    <= 1'b0;
`endif
                            state    <= ST_RESP;
                        end else begin
                            state    <= ST_LOAD_A;
                        end
                    end
                end
                ST_LOAD_A: state <= ST_LOAD_B;
                ST_LOAD_B: begin
                    state <= ST_WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
                    wd_q  <= '0;
`endif
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        result_q <= eng_result;
`ifdef GCD_ARB_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                        state    <= ST_RESP;
                    end
`ifdef GCD_ARB_TIMEOUT_EN
                    else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign eng_start = (state == ST_LOAD_A);
    assign eng_data  = (state == ST_LOAD_A) ? a_q :
                       (state == ST_LOAD_B) ? b_q : '0;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = (state == ST_RESP) && (id_q == IW'(i));
        end
    end

    assign rsp_data = (state == ST_RESP) ? result_q : '0;
`ifdef GCD_ARB_TIMEOUT_EN
    assign rsp_err  = (state == ST_RESP) && err_q;
`else
    assign rsp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Directed bench for gcd_req_arbiter: engine handshake, round-robin order, bypass, reset, watchdog.
module tb_gcd_req_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  eng_start;
    logic [WIDTH-1:0]      eng_data;
    logic                  eng_done;
    logic [WIDTH-1:0]      eng_result;

    int checks = 0;
    int errors = 0;

    gcd_req_arbiter #(
        .NREQ        (NREQ),
        .WIDTH       (WIDTH),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_data   (eng_data),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // Accept requester id and walk LOAD_A/LOAD_B; returns in the first WAIT cycle.
    task automatic start_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input bit drop);
        settle();
        check("ready_grant", 32'(req_ready), 32'(1 << id));
        tick();
        if (drop) req_valid = '0;
        settle();
        check("load_a_start", 32'(eng_start), 32'd1);
        check("load_a_data", 32'(eng_data), 32'(a));
        check("busy_no_ready", 32'(req_ready), 32'd0);
        tick();
        check("load_b_start", 32'(eng_start), 32'd0);
        check("load_b_data", 32'(eng_data), 32'(b));
        tick();
        check("wait_data_zero", 32'(eng_data), 32'd0);
    endtask

    task automatic do_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int waits, input logic [WIDTH-1:0] res, input bit drop);
        start_op(id, a, b, drop);
        repeat (waits) begin
            check("wait_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        eng_done   = 1'b1;
        eng_result = res;
        tick();
        eng_done   = 1'b0;
        check("rsp_valid", 32'(rsp_valid), 32'(1 << id));
        check("rsp_data", 32'(rsp_data), 32'(res));
        check("rsp_err", 32'(rsp_err), 32'd0);
        tick();
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    task automatic bypass_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] res);
        req_valid = '0;
        req_valid[id] = 1'b1;
        set_ops(id, a, b);
        settle();
        check("byp_ready", 32'(req_ready), 32'(1 << id));
        tick();
        req_valid = '0;
        settle();
        check("byp_rsp_valid", 32'(rsp_valid), 32'(1 << id));
        check("byp_rsp_data", 32'(rsp_data), 32'(res));
        check("byp_no_start", 32'(eng_start), 32'd0);
        check("byp_eng_data", 32'(eng_data), 32'd0);
        tick();
        check("byp_rsp_clear", 32'(rsp_valid), 32'd0);
        check("byp_no_start2", 32'(eng_start), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        eng_done   = 1'b0;
        eng_result = '0;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_eng_data", 32'(eng_data), 32'd0);
        rst = 1'b0;

        // gcd(143,78) = 13, engine takes three WAIT cycles
        req_valid = 4'b0001;
        set_ops(0, 16'd143, 16'd78);
        do_op(0, 16'd143, 16'd78, 2, 16'd13, 1'b1);

        // Fresh reset so requester 0 leads the rotation.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            set_ops(i, 16'(12 * (i + 1)), 16'(18 * (i + 1)));
        end
        req_valid = 4'b1111;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                do_op(i, 16'(12 * (i + 1)), 16'(18 * (i + 1)), (r + i) % 3,
                      16'(6 * (i + 1)), 1'b0);
            end
        end
        req_valid = '0;

        bypass_op(2, 16'd0, 16'd45, 16'd45);
        bypass_op(2, 16'd0, 16'd0, 16'd0);
        bypass_op(1, 16'd27, 16'd0, 16'd27);

        // Reset coinciding with eng_done in WAIT abandons the operation.
        req_valid = 4'b0010;
        set_ops(1, 16'd10, 16'd4);
        start_op(1, 16'd10, 16'd4, 1'b1);
        tick();
        rst        = 1'b1;
        eng_done   = 1'b1;
        eng_result = 16'd2;
        tick();
        check("rst_wait_no_rsp", 32'(rsp_valid), 32'd0);
        check("rst_wait_eng_data", 32'(eng_data), 32'd0);
        rst = 1'b0;
        tick();
        check("late_done_no_rsp", 32'(rsp_valid), 32'd0);
        eng_done  = 1'b0;
        req_valid = 4'b0011;
        settle();
        check("post_rst_prio0", 32'(req_ready), 32'd1);
        req_valid = 4'b0010;
        settle();
        check("drop_before_accept", 32'(req_ready), 32'b0010);
        req_valid = '0;
        settle();
        check("no_req_no_ready", 32'(req_ready), 32'd0);

        // Spurious eng_done in IDLE
        eng_done   = 1'b1;
        eng_result = 16'd99;
        tick();
        tick();
        check("spur_no_rsp", 32'(rsp_valid), 32'd0);
        check("spur_rsp_data", 32'(rsp_data), 32'd0);
        check("spur_no_start", 32'(eng_start), 32'd0);
        eng_done = 1'b0;
        bypass_op(3, 16'd5, 16'd0, 16'd5);

`ifdef GCD_ARB_TIMEOUT_EN
        req_valid = 4'b0001;
        set_ops(0, 16'd9, 16'd6);
        start_op(0, 16'd9, 16'd6, 1'b1);
        repeat (7) begin
            check("wd_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        tick();
        check("wd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wd_rsp_data", 32'(rsp_data), 32'd0);
        check("wd_rsp_err", 32'(rsp_err), 32'd1);
        tick();

        req_valid = 4'b0001;
        start_op(0, 16'd9, 16'd6, 1'b1);
        repeat (7) tick();
        eng_done   = 1'b1;
        eng_result = 16'd3;
        tick();
        eng_done   = 1'b0;
        check("wd_tie_valid", 32'(rsp_valid), 32'd1);
        check("wd_tie_data", 32'(rsp_data), 32'd3);
        check("wd_tie_err", 32'(rsp_err), 32'd0);
        tick();
`else
        // No watchdog: WAIT is held indefinitely until eng_done.
        req_valid = 4'b0001;
        set_ops(0, 16'd9, 16'd6);
        start_op(0, 16'd9, 16'd6, 1'b1);
        repeat (20) begin
            check("unbounded_wait", 32'(rsp_valid), 32'd0);
            tick();
        end
        eng_done   = 1'b1;
        eng_result = 16'd3;
        tick();
        eng_done   = 1'b0;
        check("long_rsp_valid", 32'(rsp_valid), 32'd1);
        check("long_rsp_data", 32'(rsp_data), 32'd3);
        check("long_rsp_err", 32'(rsp_err), 32'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
